// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_e   : loader FSM states
//   WORD_W    : instruction word width
//   ADDR_STEP : byte stride between consecutive instruction words
//   COUNT_W   : width of the word-count field and word index
package imem_loader_pkg;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_e;

  localparam int WORD_W    = 32;
  localparam int ADDR_STEP = 4;
  localparam int COUNT_W   = 16;

  // Byte address of a word index; ADDR_STEP is 4, so this is a 2-bit shift.
  function automatic logic [COUNT_W+1:0] word_byte_addr(input logic [COUNT_W-1:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs an MSB-first byte stream into 32-bit words.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : drop any partial word (FSM consumed the word)
//   shift_en  : a byte is transferred this cycle
//   byte_in   : the byte being transferred
//   word      : assembled word, valid in the cycle word_full is high
//   word_full : the byte in flight is the 4th of the word
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  // Only the first three bytes are stored; the 4th is passed straight
  // through so the word is available on the same edge it completes.
  logic [23:0] sh_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (shift_en) begin
      sh_q  <= {sh_q[15:0], byte_in};
      cnt_q <= cnt_q + 2'd1;
    end
  end

  assign word      = {sh_q, byte_in};
  assign word_full = shift_en && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Accepts a 16-bit big-endian word
// count followed by that many big-endian 32-bit instructions and writes
// them to consecutive word addresses from 0, holding the core until done.
//   clk, rst   : clock, synchronous active-high reset
//   byte_valid : upstream byte present
//   byte_data  : stream byte
//   byte_ready : loader accepts a byte this cycle
//   mem_we     : one-cycle instruction-memory write strobe
//   mem_addr   : write byte address (multiple of 4)
//   mem_wdata  : instruction word
//   core_hold  : freeze PC/pipeline (low only after a complete load)
//   done       : load completed (sticky until rst)
//   error      : count exceeded DEPTH (sticky until rst)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);

  state_e               state_q, state_d;
  logic                 live_q;      // low for the first cycle out of reset
  logic [7:0]           cnt_hi_q;
  logic [COUNT_W-1:0]   count_q;
  logic [COUNT_W-1:0]   idx_q;
  logic                 mem_we_q;
  logic [AW-1:0]        mem_addr_q;
  logic [WORD_W-1:0]    mem_wdata_q;

  logic                 accept;
  logic [COUNT_W-1:0]   count_in;
  logic [WORD_W-1:0]    asm_word;
  logic                 asm_full;

  // State resets to CNT_HI, but live_q keeps byte_ready low until the
  // first edge with rst low has been seen.
  assign byte_ready = live_q &&
                      (state_q == CNT_HI || state_q == CNT_LO || state_q == DATA);
  assign accept     = byte_valid && byte_ready;
  assign count_in   = {cnt_hi_q, byte_data};

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q == WRITE),
    .shift_en  (accept && state_q == DATA),
    .byte_in   (byte_data),
    .word      (asm_word),
    .word_full (asm_full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      CNT_HI: if (accept) state_d = CNT_LO;
      CNT_LO: if (accept) begin
        if (count_in == '0)          state_d = DONE;
        else if (count_in > DEPTH_C) state_d = ERR;
        else                         state_d = DATA;
      end
      DATA:   if (asm_full) state_d = WRITE;
      WRITE:  state_d = (idx_q + 1'b1 == count_q) ? DONE : DATA;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CNT_HI;
      live_q      <= 1'b0;
      cnt_hi_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      live_q   <= 1'b1;
      state_q  <= state_d;
      mem_we_q <= asm_full;
      if (state_q == CNT_HI && accept) cnt_hi_q <= byte_data;
      if (state_q == CNT_LO && accept) begin
        count_q <= count_in;
        idx_q   <= '0;
      end
      if (state_q == WRITE) idx_q <= idx_q + 1'b1;
      // Address and data are captured with the 4th byte, so they are
      // stable throughout the following write cycle.
      if (asm_full) begin
        mem_addr_q  <= AW'(word_byte_addr(idx_q));
        mem_wdata_q <= asm_word;
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_hold = (state_q != DONE);
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERR);

endmodule
